// File: rtl/motor_position_servo.sv
// Closed-loop lift position servo: quadrature decode, three-speed band profile,
// start/settle/stall FSM and a dead-timed dual-PWM H-bridge driver.
module motor_position_servo #(
  parameter int POS_W      = 32,
  parameter int CNT_W      = 8,
  parameter int FLOOR_LEN  = 7000,
  parameter int PWM_PERIOD = 1000,
  parameter int FAST_BAND  = 500,
  parameter int MID_BAND   = 100,
  parameter int STOP_BAND  = 10,
  parameter int FAST_DUTY  = 1000,
  parameter int MID_DUTY   = 600,
  parameter int SLOW_DUTY  = 380,
  parameter int SETTLE_CYC = 1000,
  parameter int STALL_CYC  = 1000000
) (
  input  logic             motor_clk,
  input  logic             motor_reset,
  input  logic             move_start,
  input  logic [CNT_W-1:0] move_floor_cnt,
  input  logic             move_abort,
  input  logic [1:0]       move_encoder,
  output logic             motor_A,
  output logic             motor_B,
  output logic             move_busy,
  output logic             move_done,
  output logic             move_fault,
  output logic [POS_W-1:0] position,
  output logic [POS_W-1:0] target
);

  localparam int PwmW    = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam int DutyW   = $clog2(PWM_PERIOD + 1);
  localparam int SettleW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam int StallW  = (STALL_CYC > 1) ? $clog2(STALL_CYC) : 1;
  localparam int ErrW    = POS_W + 1;
  localparam int FastD   = (FAST_DUTY > PWM_PERIOD) ? PWM_PERIOD : FAST_DUTY;
  localparam int MidD    = (MID_DUTY > PWM_PERIOD) ? PWM_PERIOD : MID_DUTY;
  localparam int SlowD   = (SLOW_DUTY > PWM_PERIOD) ? PWM_PERIOD : SLOW_DUTY;

  typedef enum logic [1:0] {StIdle, StMove, StSettle, StFault} state_e;

  state_e              state_q, state_d;
  logic [1:0]          enc_meta_q, enc_sync_q, enc_prev_q;
  logic [POS_W-1:0]    position_q, target_q, target_d;
  logic [SettleW-1:0]  settle_q, settle_d;
  logic [StallW-1:0]   stall_q, stall_d;
  logic [PwmW-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic [DutyW-1:0]    duty_q, duty_d, band_duty;
  logic                dir_q, dir_d;
  logic [1:0]          enc_diff;
  logic                cnt_up, cnt_dn, pos_change;
  logic [POS_W-1:0]    floor_ext, step;
  logic signed [ErrW-1:0] err;
  logic [ErrW-1:0]     err_abs;
  logic                in_band, dir_rev, drive_en, pwm_wrap, pwm_on, done;

  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  // Gray index difference: +1 forward, -1 reverse, 2 is an illegal double jump
  assign enc_diff   = gray2bin(enc_sync_q) - gray2bin(enc_prev_q);
  assign cnt_up     = (enc_diff == 2'd1);
  assign cnt_dn     = (enc_diff == 2'd3);
  assign pos_change = cnt_up | cnt_dn;

  assign floor_ext = {{(POS_W - CNT_W){move_floor_cnt[CNT_W-1]}}, move_floor_cnt};
  assign step      = floor_ext * POS_W'(FLOOR_LEN);

  assign err     = $signed({target_q[POS_W-1], target_q}) - $signed({position_q[POS_W-1], position_q});
  assign err_abs = err[ErrW-1] ? $unsigned(-err) : $unsigned(err);
  assign in_band = (err_abs <= ErrW'(STOP_BAND));
  assign dir_rev = err[ErrW-1];

  always_comb begin
    band_duty = '0;
    if (err_abs > ErrW'(FAST_BAND))      band_duty = DutyW'(FastD);
    else if (err_abs > ErrW'(MID_BAND))  band_duty = DutyW'(MidD);
    else if (err_abs > ErrW'(STOP_BAND)) band_duty = DutyW'(SlowD);
  end

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    settle_d = settle_q;
    stall_d  = '0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (move_start && !move_abort) begin
          target_d = target_q + step;
          state_d  = StMove;
        end
      end
      StMove: begin
        stall_d = pos_change ? '0 : stall_q + StallW'(1);
        if (move_abort) begin
          target_d = position_q;
          state_d  = StIdle;
        end else if (in_band) begin
          settle_d = '0;
          state_d  = StSettle;
        end else if (!pos_change && stall_q == StallW'(STALL_CYC - 1)) begin
          state_d = StFault;
        end
      end
      StSettle: begin
        if (move_abort) begin
          target_d = position_q;
          state_d  = StIdle;
        end else if (!in_band) begin
          state_d = StMove;
        end else if (settle_q == SettleW'(SETTLE_CYC - 1)) begin
          done    = 1'b1;
          state_d = StIdle;
        end else begin
          settle_d = settle_q + SettleW'(1);
        end
      end
      StFault: begin
        if (move_abort) begin
          target_d = position_q;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign drive_en = (state_q == StMove) && !move_abort && !in_band;
  assign pwm_wrap = (pwm_cnt_q == PwmW'(PWM_PERIOD - 1));

  // Duty/direction only change at wrap; a reversal first latches one empty period
  always_comb begin
    pwm_cnt_d = pwm_wrap ? '0 : pwm_cnt_q + PwmW'(1);
    duty_d    = duty_q;
    dir_d     = dir_q;
    if (!drive_en) begin
      duty_d = '0;
    end else if (pwm_wrap) begin
      if (dir_rev != dir_q) begin
        duty_d = '0;
        dir_d  = dir_rev;
      end else begin
        duty_d = band_duty;
      end
    end
  end

  always_ff @(posedge motor_clk or posedge motor_reset) begin
    if (motor_reset) begin
      state_q    <= StIdle;
      enc_meta_q <= '0;
      enc_sync_q <= '0;
      enc_prev_q <= '0;
      position_q <= '0;
      target_q   <= '0;
      settle_q   <= '0;
      stall_q    <= '0;
      pwm_cnt_q  <= '0;
      duty_q     <= '0;
      dir_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      enc_meta_q <= move_encoder;
      enc_sync_q <= enc_meta_q;
      enc_prev_q <= enc_sync_q;
      if (cnt_up)      position_q <= position_q + POS_W'(1);
      else if (cnt_dn) position_q <= position_q - POS_W'(1);
      target_q   <= target_d;
      settle_q   <= settle_d;
      stall_q    <= stall_d;
      pwm_cnt_q  <= pwm_cnt_d;
      duty_q     <= duty_d;
      dir_q      <= dir_d;
    end
  end

  assign pwm_on     = (DutyW'(pwm_cnt_q) < duty_q);
  assign motor_A    = drive_en && pwm_on && !dir_q;
  assign motor_B    = drive_en && pwm_on && dir_q;
  assign move_busy  = (state_q == StMove) || (state_q == StSettle);
  assign move_fault = (state_q == StFault);
  assign move_done  = done;
  assign position   = position_q;
  assign target     = target_q;

endmodule

// File: doc/motor_position_servo.md
Name: motor_position_servo

Overview:
- Parametrised closed-loop position servo for the lift drive motor: quadrature encoder decoder, three-speed distance profile, and a glitch-free dual-PWM H-bridge driver.
- Sits between the floor scheduler (issues signed relative floor moves) and the motor driver pins.
- Adds to the existing motor path: start/busy/done handshake, abort, settle qualification, stall fault, direction dead time, and fully parametrised bands/duties/widths.

Parameters:
- POS_W, 32: width of position/target registers (signed, two's complement).
- CNT_W, 8: width of signed floor-count input.
- FLOOR_LEN, 7000: encoder counts per floor.
- PWM_PERIOD, 1000: PWM period in clocks.
- FAST_BAND, 500: |error| above this uses FAST_DUTY.
- MID_BAND, 100: |error| above this uses MID_DUTY.
- STOP_BAND, 10: |error| above this uses SLOW_DUTY; at or below, brake.
- FAST_DUTY, 1000: high clocks per period, fast.
- MID_DUTY, 600: high clocks per period, mid.
- SLOW_DUTY, 380: high clocks per period, slow.
- SETTLE_CYC, 1000: consecutive in-band clocks required before done.
- STALL_CYC, 1000000: clocks without any encoder count while driving before fault.

Ports:
- motor_clk  in  1  single system clock.
- motor_reset  in  1  asynchronous, active-high reset.
- move_start  in  1  one-cycle request; sampled in IDLE only.
- move_floor_cnt  in  CNT_W  signed floors to travel; sampled with move_start.
- move_abort  in  1  level; cancels move or clears fault.
- move_encoder  in  2  raw quadrature {A,B}, asynchronous.
- motor_A  out  1  forward PWM.
- motor_B  out  1  reverse PWM.
- move_busy  out  1  high in MOVE/SETTLE.
- move_done  out  1  one-cycle pulse on successful settle.
- move_fault  out  1  high in FAULT.
- position  out  POS_W  signed current encoder count.
- target  out  POS_W  signed goal count.

Behaviour:
- Reset (async assert, sync release): position=0, target=0, state=IDLE, PWM counter=0, all outputs 0.
- Encoder:
  - 2-flop synchroniser, then an x4 decode against the previous synchronised state.
  - 00→01→11→10→00 increments; the reverse sequence decrements.
  - No change: hold. Both bits change: illegal, ignored, previous state updated.
  - Input edge is visible on position 3 clocks later. Position wraps modulo 2^POS_W.
- Error: e = target − position, computed in POS_W+1 bits signed; |e| is used for band selection.
  - Duty: |e|>FAST_BAND → FAST_DUTY; else >MID_BAND → MID_DUTY; else >STOP_BAND → SLOW_DUTY; else 0 (brake).
  - Direction: e>0 → forward (motor_A); e<0 → reverse (motor_B).
- FSM:
  - IDLE: drive off.
    - move_start=1 and move_abort=0: target += sign-extended move_floor_cnt*FLOOR_LEN (mod 2^POS_W), go to MOVE.
    - move_busy is high the next cycle.
    - start and abort in the same cycle: abort wins, start dropped.
  - MOVE: drive per duty/direction. |e|≤STOP_BAND → SETTLE with settle counter=0.
  - SETTLE: brake.
    - Settle counter increments each cycle |e|≤STOP_BAND; leaving the band → back to MOVE.
    - Counter reaches SETTLE_CYC−1 → move_done=1 for one cycle, go to IDLE.
    - A floor count of 0 therefore completes after SETTLE_CYC+1 clocks.
  - Stall: in MOVE, stall counter clears on every position change or on state entry and counts otherwise. Reaching STALL_CYC → FAULT.
  - FAULT: drive off, move_fault=1, move_start ignored. move_abort → target<=position, IDLE.
  - move_abort in MOVE/SETTLE: target<=position, IDLE next cycle, no move_done, drive off within one PWM period boundary rule below.
- move_start while busy or in FAULT is ignored; target is unchanged.
- PWM:
  - Counter runs 0..PWM_PERIOD−1 and wraps. Output is high while counter < latched duty.
  - Duty 0 → always low; duty ≥PWM_PERIOD → always high.
  - Duty and direction are latched only at counter wrap, so there are no runt pulses.
  - Exceptions: brake, abort, FAULT and reset force both outputs low immediately.
  - Direction reversal at latch inserts one full period with both outputs low before the new direction.
  - motor_A and motor_B are never high in the same cycle.

Test Plan:
- Reset mid-move (state MOVE, motor_A toggling) → all outputs 0 asynchronously; after release, position=0, target=0, IDLE.
- move_floor_cnt=+1, encoder stepped forward 7000 counts → target=7000; motor_A duty 1000 until e≤500, then 600, then 380 at e≤100; brake at e≤10; move_done pulses once after 1000 in-band clocks; motor_B stays 0 throughout.
- move_floor_cnt=−2 from position 7000 → target=−7000; motor_B active.
  - Overshoot to −7020 → returns to MOVE, motor_A drives after one dead period.
  - done only after a stable settle.
- Encoder frozen during MOVE with STALL_CYC=50 → move_fault=1 at clock 50, outputs 0; move_start ignored; move_abort → IDLE, target=position, fault 0.
- Illegal encoder jumps 00→11 and 01→10 → position unchanged; move_start together with move_abort in IDLE → no move, busy stays 0.
- Duty change from 1000 to 600 mid-period → the current period completes high; the next period has exactly 600 high clocks; wrap from 999 to 0 is verified.
